// File: rtl/metadata_server_if.sv
// Handshake/bus bundle between the song-control side and the metadata server.
// Signal names match the original flat port list.
interface metadata_server_if #(
    parameter int SLOTS = 37,
    parameter int WIDTH = 16
);
    logic                   pause;
    logic [SLOTS-1:0]       metadata_request;
    logic [WIDTH-1:0]       note_data;
    logic                   note_valid;
    logic                   note_ready;
    logic [SLOTS*WIDTH-1:0] metadata_link;
    logic [SLOTS-1:0]       pending;
    logic                   fill_done;
    logic                   song_done;

    modport master (
        output pause, metadata_request, note_data, note_valid,
        input  note_ready, metadata_link, pending, fill_done, song_done
    );

    modport slave (
        input  pause, metadata_request, note_data, note_valid,
        output note_ready, metadata_link, pending, fill_done, song_done
    );
endinterface

// File: rtl/metadata_server.sv
// Holds one metadata word per note slot and refills requested slots from the
// upstream note stream, lowest pending slot first; zero-fills after end of song.
module metadata_server #(
    parameter int               SLOTS    = 37,
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] END_WORD = 16'hFFFF
) (
    input logic              clk,
    input logic              reset,
    metadata_server_if.slave bus
);
    localparam int SEL_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic {RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SLOTS-1:0]       pending_q, pending_d;
    logic [SLOTS*WIDTH-1:0] link_q, link_d;
    logic                   fill_done_q, fill_done_d;
    logic [SEL_W-1:0]       sel;
    logic                   xfer;

    // Descending scan so the lowest pending index is the last one assigned.
    always_comb begin
        sel = '0;
        for (int unsigned i = SLOTS; i > 0; i--) begin
            if (pending_q[i-1]) sel = SEL_W'(i - 1);
        end
    end

    assign bus.note_ready = (state_q == RUN) && (|pending_q) && !bus.pause && !reset;
    assign xfer           = bus.note_valid && bus.note_ready;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        link_d      = link_q;
        fill_done_d = fill_done_q || (pending_q == '0);
        case (state_q)
            RUN: begin
                if (xfer) begin
                    if (bus.note_data == END_WORD) begin
                        state_d = DONE;
                    end else begin
                        link_d[sel*WIDTH +: WIDTH] = bus.note_data;
                        pending_d[sel]             = 1'b0;
                    end
                end
            end
            DONE: begin
                if (!bus.pause && (|pending_q)) begin
                    link_d[sel*WIDTH +: WIDTH] = '0;
                    pending_d[sel]             = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase
        // A request in the same cycle as service keeps the slot pending.
        pending_d = pending_d | bus.metadata_request;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            pending_q   <= '1;
            link_q      <= '0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            link_q      <= link_d;
            fill_done_q <= fill_done_d;
        end
    end

    assign bus.metadata_link = link_q;
    assign bus.pending       = pending_q;
    assign bus.fill_done     = fill_done_q;
    assign bus.song_done     = (state_q == DONE);
endmodule

// File: tb/tb_metadata_server.sv
// Directed bench for metadata_server: fill, refill, priority, back-pressure,
// pause, end of song and reset mid-fill.
module tb_metadata_server;
    localparam int SLOTS = 37;
    localparam int WIDTH = 16;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [WIDTH-1:0] exp_slot [SLOTS];

    metadata_server_if #(.SLOTS(SLOTS), .WIDTH(WIDTH)) bus ();

    metadata_server #(.SLOTS(SLOTS), .WIDTH(WIDTH), .END_WORD(16'hFFFF)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SLOTS*WIDTH-1:0] pack_exp();
        logic [SLOTS*WIDTH-1:0] v;
        for (int i = 0; i < SLOTS; i++) v[i*WIDTH +: WIDTH] = exp_slot[i];
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.pause = 1'b0;
        bus.metadata_request = '0;
        bus.note_valid = 1'b0;
        bus.note_data = '0;
        for (int i = 0; i < SLOTS; i++) exp_slot[i] = '0;
        step();
        step();
        total++; if (bus.metadata_link !== pack_exp()) begin bad++; $display("FAIL reset_link got=%h exp=%h", bus.metadata_link, pack_exp()); end
        total++; if (bus.pending !== {SLOTS{1'b1}}) begin bad++; $display("FAIL reset_pending got=%h exp=%h", bus.pending, {SLOTS{1'b1}}); end
        total++; if (bus.note_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.note_ready); end
        total++; if (bus.fill_done !== 1'b0) begin bad++; $display("FAIL reset_fill_done got=%b exp=0", bus.fill_done); end
        total++; if (bus.song_done !== 1'b0) begin bad++; $display("FAIL reset_song_done got=%b exp=0", bus.song_done); end
    endtask

    task automatic test_initial_fill();
        int   words;
        logic fire;
        words = 0;
        reset = 1'b0;
        bus.note_valid = 1'b1;
        bus.note_data = 16'h0100;
        for (int c = 1; c <= 40; c++) begin
            #1;
            fire = bus.note_ready;
            step();
            if (fire) begin
                words++;
                bus.note_data = 16'h0100 + 16'(words);
            end
            if (c == 37) begin
                total++; if (bus.fill_done !== 1'b0) begin bad++; $display("FAIL fill_done_early got=%b exp=0", bus.fill_done); end
            end
            if (c == 38) begin
                total++; if (bus.fill_done !== 1'b1) begin bad++; $display("FAIL fill_done_at_38 got=%b exp=1", bus.fill_done); end
            end
        end
        total++; if (words !== 37) begin bad++; $display("FAIL fill_word_count got=%0d exp=37", words); end
        total++; if (bus.note_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_after got=%b exp=0", bus.note_ready); end
        for (int i = 0; i < SLOTS; i++) exp_slot[i] = 16'h0100 + 16'(i);
        total++; if (bus.metadata_link !== pack_exp()) begin bad++; $display("FAIL fill_link got=%h exp=%h", bus.metadata_link, pack_exp()); end
        total++; if (bus.pending !== '0) begin bad++; $display("FAIL fill_pending got=%h exp=0", bus.pending); end
        bus.note_valid = 1'b0;
    endtask

    task automatic test_single_refill();
        logic [SLOTS-1:0] m;
        bus.metadata_request = '0;
        bus.metadata_request[5] = 1'b1;
        bus.note_valid = 1'b1;
        bus.note_data = 16'hABCD;
        #1;
        total++; if (bus.note_ready !== 1'b0) begin bad++; $display("FAIL refill_ready_n got=%b exp=0", bus.note_ready); end
        step();
        bus.metadata_request = '0;
        #1;
        m = '0; m[5] = 1'b1;
        total++; if (bus.note_ready !== 1'b1) begin bad++; $display("FAIL refill_ready_n1 got=%b exp=1", bus.note_ready); end
        total++; if (bus.pending !== m) begin bad++; $display("FAIL refill_pending got=%h exp=%h", bus.pending, m); end
        step();
        exp_slot[5] = 16'hABCD;
        total++; if (bus.metadata_link !== pack_exp()) begin bad++; $display("FAIL refill_link got=%h exp=%h", bus.metadata_link, pack_exp()); end
        total++; if (bus.pending !== '0) begin bad++; $display("FAIL refill_pending_clr got=%h exp=0", bus.pending); end
        bus.note_valid = 1'b0;
    endtask

    task automatic test_priority();
        logic [SLOTS-1:0] m;
        logic [15:0]      words [3];
        int               order [3];
        words[0] = 16'h2002; words[1] = 16'h3017; words[2] = 16'h4030;
        order[0] = 2; order[1] = 17; order[2] = 30;
        bus.metadata_request = '0;
        bus.metadata_request[30] = 1'b1;
        bus.metadata_request[2]  = 1'b1;
        bus.metadata_request[17] = 1'b1;
        bus.note_valid = 1'b1;
        bus.note_data = words[0];
        step();
        bus.metadata_request = '0;
        m = '0; m[2] = 1'b1; m[17] = 1'b1; m[30] = 1'b1;
        total++; if (bus.pending !== m) begin bad++; $display("FAIL prio_pending got=%h exp=%h", bus.pending, m); end
        for (int k = 0; k < 3; k++) begin
            bus.note_data = words[k];
            step();
            exp_slot[order[k]] = words[k];
            m[order[k]] = 1'b0;
            total++; if (bus.metadata_link !== pack_exp()) begin bad++; $display("FAIL prio_order_%0d got=%h exp=%h", k, bus.metadata_link, pack_exp()); end
            total++; if (bus.pending !== m) begin bad++; $display("FAIL prio_pending_%0d got=%h exp=%h", k, bus.pending, m); end
        end
        // collision: slot 2 re-requested in the cycle it is served
        bus.metadata_request[2] = 1'b1;
        bus.note_data = 16'h5002;
        step();
        step();
        bus.metadata_request = '0;
        exp_slot[2] = 16'h5002;
        m = '0; m[2] = 1'b1;
        total++; if (bus.metadata_link !== pack_exp()) begin bad++; $display("FAIL coll_first got=%h exp=%h", bus.metadata_link, pack_exp()); end
        total++; if (bus.pending !== m) begin bad++; $display("FAIL coll_set_wins got=%h exp=%h", bus.pending, m); end
        bus.note_data = 16'h6002;
        step();
        exp_slot[2] = 16'h6002;
        total++; if (bus.metadata_link !== pack_exp()) begin bad++; $display("FAIL coll_second got=%h exp=%h", bus.metadata_link, pack_exp()); end
        total++; if (bus.pending !== '0) begin bad++; $display("FAIL coll_pending_clr got=%h exp=0", bus.pending); end
        bus.note_valid = 1'b0;
    endtask

    task automatic test_backpressure_pause();
        logic [SLOTS-1:0] m;
        bus.note_valid = 1'b0;
        bus.metadata_request = '0;
        bus.metadata_request[0] = 1'b1;
        step();
        bus.metadata_request = '0;
        m = '0; m[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            total++; if (bus.pending !== m || bus.metadata_link !== pack_exp()) begin bad++; $display("FAIL bp_hold_%0d got=%h exp=%h", c, bus.pending, m); end
        end
        bus.pause = 1'b1;
        bus.note_valid = 1'b1;
        bus.note_data = 16'h7000;
        bus.metadata_request[1] = 1'b1;
        #1;
        total++; if (bus.note_ready !== 1'b0) begin bad++; $display("FAIL pause_ready got=%b exp=0", bus.note_ready); end
        step();
        bus.metadata_request = '0;
        m[1] = 1'b1;
        total++; if (bus.pending !== m) begin bad++; $display("FAIL pause_req_sets got=%h exp=%h", bus.pending, m); end
        for (int c = 0; c < 2; c++) begin
            step();
            total++; if (bus.metadata_link !== pack_exp() || bus.note_ready !== 1'b0) begin bad++; $display("FAIL pause_no_write_%0d got=%b exp=0", c, bus.note_ready); end
        end
        bus.pause = 1'b0;
        #1;
        total++; if (bus.note_ready !== 1'b1) begin bad++; $display("FAIL unpause_ready got=%b exp=1", bus.note_ready); end
        step();
        exp_slot[0] = 16'h7000;
        total++; if (bus.metadata_link !== pack_exp()) begin bad++; $display("FAIL unpause_slot0 got=%h exp=%h", bus.metadata_link, pack_exp()); end
        bus.note_data = 16'h7001;
        step();
        exp_slot[1] = 16'h7001;
        total++; if (bus.metadata_link !== pack_exp() || bus.pending !== '0) begin bad++; $display("FAIL unpause_slot1 got=%h exp=%h", bus.metadata_link, pack_exp()); end
        bus.note_valid = 1'b0;
    endtask

    task automatic test_end_of_song();
        logic [SLOTS-1:0] m;
        bus.metadata_request = '0;
        bus.metadata_request[3] = 1'b1;
        bus.metadata_request[4] = 1'b1;
        bus.note_valid = 1'b1;
        bus.note_data = 16'hFFFF;
        step();
        bus.metadata_request = '0;
        #1;
        total++; if (bus.note_ready !== 1'b1 || bus.song_done !== 1'b0) begin bad++; $display("FAIL eos_ready got=%b exp=1", bus.note_ready); end
        step();
        bus.note_valid = 1'b0;
        m = '0; m[3] = 1'b1; m[4] = 1'b1;
        total++; if (bus.song_done !== 1'b1) begin bad++; $display("FAIL eos_song_done got=%b exp=1", bus.song_done); end
        total++; if (bus.pending !== m || bus.metadata_link !== pack_exp()) begin bad++; $display("FAIL eos_not_written got=%h exp=%h", bus.pending, m); end
        total++; if (bus.note_ready !== 1'b0) begin bad++; $display("FAIL eos_ready_done got=%b exp=0", bus.note_ready); end
        step();
        exp_slot[3] = '0; m[3] = 1'b0;
        total++; if (bus.metadata_link !== pack_exp() || bus.pending !== m) begin bad++; $display("FAIL eos_zero3 got=%h exp=%h", bus.metadata_link, pack_exp()); end
        step();
        exp_slot[4] = '0;
        total++; if (bus.metadata_link !== pack_exp() || bus.pending !== '0) begin bad++; $display("FAIL eos_zero4 got=%h exp=%h", bus.metadata_link, pack_exp()); end
        bus.metadata_request[10] = 1'b1;
        bus.note_valid = 1'b1;
        bus.note_data = 16'h1234;
        step();
        bus.metadata_request = '0;
        total++; if (bus.note_ready !== 1'b0) begin bad++; $display("FAIL eos_late_ready got=%b exp=0", bus.note_ready); end
        step();
        exp_slot[10] = '0;
        total++; if (bus.metadata_link !== pack_exp() || bus.song_done !== 1'b1) begin bad++; $display("FAIL eos_late_zero got=%h exp=%h", bus.metadata_link, pack_exp()); end
        total++; if (bus.fill_done !== 1'b1) begin bad++; $display("FAIL fill_done_sticky got=%b exp=1", bus.fill_done); end
        bus.note_valid = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        logic [SLOTS-1:0] m;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < SLOTS; i++) exp_slot[i] = '0;
        bus.note_valid = 1'b1;
        bus.note_data = 16'h8000;
        for (int k = 0; k < 10; k++) begin
            step();
            exp_slot[k] = 16'h8000 + 16'(k);
            bus.note_data = 16'h8000 + 16'(k + 1);
        end
        total++; if (bus.metadata_link !== pack_exp()) begin bad++; $display("FAIL midfill_link got=%h exp=%h", bus.metadata_link, pack_exp()); end
        reset = 1'b1;
        #1;
        total++; if (bus.note_ready !== 1'b0) begin bad++; $display("FAIL midfill_reset_ready got=%b exp=0", bus.note_ready); end
        step();
        reset = 1'b0;
        for (int i = 0; i < SLOTS; i++) exp_slot[i] = '0;
        total++; if (bus.metadata_link !== pack_exp()) begin bad++; $display("FAIL midfill_cleared got=%h exp=%h", bus.metadata_link, pack_exp()); end
        total++; if (bus.pending !== {SLOTS{1'b1}} || bus.fill_done !== 1'b0 || bus.song_done !== 1'b0) begin bad++; $display("FAIL midfill_state got=%h exp=%h", bus.pending, {SLOTS{1'b1}}); end
        bus.note_data = 16'h9000;
        step();
        exp_slot[0] = 16'h9000;
        m = '1; m[0] = 1'b0;
        total++; if (bus.metadata_link !== pack_exp() || bus.pending !== m) begin bad++; $display("FAIL midfill_restart got=%h exp=%h", bus.pending, m); end
        bus.note_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_initial_fill();
        test_single_refill();
        test_priority();
        test_backpressure_pause();
        test_end_of_song();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/metadata_server.md
# metadata_server

Responder end of the `metadata_request` / `metadata_link` interface between the song-control block and the control/loader block. It holds one 16-bit note-metadata word per note slot and presents all slots on `metadata_link`. When a slot is requested, it pulls the next word from the upstream note stream (SD-card reader side) through a valid/ready handshake and refills that slot. It sits inside the control/loader block, between the SD note stream and the song-control block.

## Interface
Parameters:
- `SLOTS`, 37, number of note slots.
- `WIDTH`, 16, bits per metadata word.
- `END_WORD`, 16'hFFFF, end-of-song marker on the note stream. It is never written into a slot.

Ports:
- `clk`  in  1  system clock (100 MHz domain); the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `pause`  in  1  while high, no transfers occur and all slot contents and pending state hold.
- `metadata_request`  in  SLOTS  bit i high for a cycle = slot i consumed, refill it; every high cycle counts as one request.
- `note_data`  in  WIDTH  upstream note word.
- `note_valid`  in  1  `note_data` is valid.
- `note_ready`  out  1  block accepts `note_data` this cycle.
- `metadata_link`  out  SLOTS*WIDTH  slot i occupies bits [i*WIDTH +: WIDTH].
- `pending`  out  SLOTS  registered; slots awaiting refill.
- `fill_done`  out  1  sticky; high once `pending` first reaches all-zero after reset.
- `song_done`  out  1  high in state DONE.

## Operation
Pending register:
- On reset: all ones, so every slot is filled from the stream after reset.
- Set: bit i is set whenever `metadata_request[i]` is high.
- Clear: bit i is cleared when slot i is served.
- Set wins: if slot i is served and requested in the same cycle, bit i stays 1.

Slot selection:
- `sel` is the lowest index with `pending` = 1, from a combinational priority encoder on the registered `pending`.
- At most one slot is served per cycle.

States (reset enters RUN):
- RUN:
  - `note_ready` = `|pending` & !`pause` & !`reset`.
  - A transfer occurs when `note_valid` & `note_ready`.
  - If the transferred word ≠ `END_WORD`: slot `sel` <= `note_data`, and `pending[sel]` is cleared.
  - If the transferred word = `END_WORD`: it is consumed (handshake completes), no slot is written, `pending` is unchanged, and the next state is DONE.
- DONE:
  - `note_ready` = 0 and `song_done` = 1.
  - Each cycle with !`pause` and `|pending`, slot `sel` <= 0 and `pending[sel]` is cleared (zero-fill).
  - Requests continue to set `pending` and are zero-filled the same way.
  - DONE is left only by `reset`.

Other rules:
- `fill_done` is set the first cycle registered `pending` == 0 and stays set until `reset`.
- While `pause` is high: no writes, no clears. Request bits still set `pending`.
- Reset mid-operation (including mid-handshake): a word presented in the reset cycle is not accepted. All state returns to its reset values on the next edge.

Reset values:
- `metadata_link` = 0
- `pending` = all ones
- `note_ready` = 0
- `fill_done` = 0
- `song_done` = 0

## Timing
- Request to refill: request high at cycle n → `pending` bit set at edge n+1 → served at n+1 if stream valid and slot is lowest pending → new word visible on `metadata_link` after edge n+2. Minimum latency is 2 cycles.
- Multiple pending slots are served in ascending index order, one per cycle, when the stream is continuously valid. 37 simultaneous requests drain in 37 cycles.
- `note_ready` is combinational from registered state and `pause`/`reset`. It does not depend on `note_valid`.
- Upstream back-pressure: if `note_valid` = 0, the slot stays pending indefinitely. There is no timeout.
- `song_done` goes high the cycle after the `END_WORD` transfer.
- `fill_done` goes high the cycle after the last initial-fill write.
- All outputs are registered except `note_ready`.

## Test plan
- Initial fill:
  - Stimulus: release reset; stream words 0x0100..0x0124 continuously valid.
  - Required: slot i = 0x0100+i; `fill_done` rises exactly 38 cycles after reset release; `note_ready` = 0 after that.
- Single refill:
  - Stimulus: after fill, pulse `metadata_request[5]` at cycle n with word 0xABCD valid.
  - Required: `note_ready` high at n+1; slot 5 = 0xABCD after edge n+2; other slots unchanged.
- Priority and collision:
  - Stimulus: request slots 30, 2 and 17 in the same cycle.
  - Required: served in order 2, 17, 30 on consecutive cycles.
  - Stimulus: re-request slot 2 in the cycle it is served.
  - Required: slot 2 is served again after slot 30.
- Back-pressure and pause:
  - Stimulus: request slot 0 with `note_valid` = 0 for 10 cycles.
  - Required: `pending[0]` stays 1 and the slot is unchanged.
  - Stimulus: assert `pause` with valid high.
  - Required: `note_ready` = 0; no write until pause is released.
- End of song:
  - Stimulus: request slots 3 and 4; stream 0xFFFF.
  - Required: 0xFFFF is consumed and not written; `song_done` rises the next cycle; slots 3 and 4 are zero-filled on the following two cycles; later requests are zero-filled.
- Reset mid-fill:
  - Stimulus: assert `reset` after 10 fill words, with valid held high.
  - Required: no word accepted during the reset cycle; after reset, all slots = 0, `pending` = all ones, and the fill restarts at slot 0.
